// File: rtl/cpu_types_pkg.sv
// Shared CPU types: next-PC source select and fetch-redirect controller states.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_JR  = 2'd1,
    PC_J   = 2'd2,
    PC_BR  = 2'd3
  } pcsrc_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2
  } fctrl_state_t;

  // EX-stage redirects win over ID-stage; br also wins over a same-cycle jr.
  function automatic pcsrc_t redirect_sel(input logic br, input logic jr, input logic j);
    if (br)      return PC_BR;
    else if (jr) return PC_JR;
    else if (j)  return PC_J;
    else         return PC_SEQ;
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch-control bundle between datapath/hazard unit (master) and the redirect controller (slave).
interface fetch_redirect_ctrl_if;
  import cpu_types_pkg::*;

  logic   ihit;
  logic   stall_i;
  logic   halt_i;
  logic   br_req;
  logic   jr_req;
  logic   j_req;
  logic   pred_hit;
  logic   pcen;
  pcsrc_t PCSrc;
  logic   psel;
  logic   flush_ifid;
  logic   flush_idex;
  logic   pipe_hold;
  logic   halted;

  modport master (
    output ihit, stall_i, halt_i, br_req, jr_req, j_req, pred_hit,
    input  pcen, PCSrc, psel, flush_ifid, flush_idex, pipe_hold, halted
  );

  modport slave (
    input  ihit, stall_i, halt_i, br_req, jr_req, j_req, pred_hit,
    output pcen, PCSrc, psel, flush_ifid, flush_idex, pipe_hold, halted
  );

endinterface

// File: rtl/fetch_ctrl_sat_cnt.sv
// Saturating up-counter used for fetch-controller statistics.
module fetch_ctrl_sat_cnt #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                          cnt <= '0;
    else if (inc && (cnt != {W{1'b1}})) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: steers next-PC select, PC enable and pipeline flush/hold.
// Optional statistics counters are built when FETCH_CTRL_STATS_EN is defined.
module fetch_redirect_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  fetch_redirect_ctrl_if.slave fc
`ifdef FETCH_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]     redirect_cnt,
  output logic [CNT_W-1:0]     pend_cnt
`endif
);

  fctrl_state_t state, state_n;
  pcsrc_t       src_q, src_n, sel;
  logic         halted_q;
  logic         pcen, psel, flush_ifid, flush_idex, pipe_hold;
  pcsrc_t       pcsrc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= RUN;
      src_q    <= PC_SEQ;
      halted_q <= 1'b0;
    end else begin
      state    <= state_n;
      src_q    <= src_n;
      halted_q <= (state_n == HALT);
    end
  end

  assign sel = redirect_sel(fc.br_req, fc.jr_req, fc.j_req);

  always_comb begin
    state_n    = state;
    src_n      = src_q;
    pcen       = 1'b0;
    pcsrc      = PC_SEQ;
    psel       = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    pipe_hold  = 1'b0;
    // Outputs are forced quiet while reset is held, even though state already reads RUN.
    if (nRST) begin
      unique case (state)
        RUN: begin
          if (fc.halt_i) begin
            state_n = HALT;
          end else if (sel != PC_SEQ) begin
            // stall_i is ignored: the stalled instruction is on the wrong path.
            if (fc.ihit) begin
              pcen       = 1'b1;
              pcsrc      = sel;
              flush_ifid = 1'b1;
              flush_idex = (sel != PC_J);
            end else begin
              pipe_hold = 1'b1;
              src_n     = sel;
              state_n   = PEND;
            end
          end else begin
            psel = fc.pred_hit;
            pcen = fc.ihit & ~fc.stall_i;
          end
        end
        PEND: begin
          // New requests, stall and halt are frozen/wrong-path until the redirect lands.
          pcsrc     = src_q;
          pipe_hold = 1'b1;
          pcen      = fc.ihit;
          if (fc.ihit) begin
            flush_ifid = 1'b1;
            flush_idex = (src_q != PC_J);
            state_n    = RUN;
          end
        end
        HALT: ;
        default: state_n = RUN;
      endcase
    end
  end

  assign fc.pcen       = pcen;
  assign fc.PCSrc      = pcsrc;
  assign fc.psel       = psel;
  assign fc.flush_ifid = flush_ifid;
  assign fc.flush_idex = flush_idex;
  assign fc.pipe_hold  = pipe_hold;
  assign fc.halted     = halted_q;

`ifdef FETCH_CTRL_STATS_EN
  logic redir_inc, pend_inc;
  assign redir_inc = pcen && (pcsrc != PC_SEQ);
  assign pend_inc  = (state == PEND);

  fetch_ctrl_sat_cnt #(.W(CNT_W)) u_redir_cnt (
    .CLK (CLK),
    .nRST(nRST),
    .inc (redir_inc),
    .cnt (redirect_cnt)
  );

  fetch_ctrl_sat_cnt #(.W(CNT_W)) u_pend_cnt (
    .CLK (CLK),
    .nRST(nRST),
    .inc (pend_inc),
    .cnt (pend_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
module tb_fetch_redirect_ctrl;
  import cpu_types_pkg::*;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  fetch_redirect_ctrl_if bus ();

`ifdef FETCH_CTRL_STATS_EN
  logic [CNT_W-1:0] redirect_cnt, pend_cnt;
`endif

  fetch_redirect_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .fc  (bus)
`ifdef FETCH_CTRL_STATS_EN
    ,
    .redirect_cnt(redirect_cnt),
    .pend_cnt    (pend_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // Behavioural model: "is halted", "waiting on a missed redirect" and its target.
  bit m_halted;
  bit m_waiting;
  int m_src;
  int m_redir;
  int m_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_halted  = 0;
    m_waiting = 0;
    m_src     = 0;
    m_redir   = 0;
    m_pend    = 0;
  endtask

  task automatic expect_now(output logic p, output logic [1:0] s, output logic ps,
                            output logic fi, output logic fx, output logic h);
    int want;
    want = bus.br_req ? 3 : bus.jr_req ? 1 : bus.j_req ? 2 : 0;
    p = 0; s = 0; ps = 0; fi = 0; fx = 0; h = 0;
    if (!nRST || m_halted) return;
    if (m_waiting) begin
      h = 1;
      s = 2'(m_src);
      p = bus.ihit;
      fi = bus.ihit;
      fx = bus.ihit && (m_src != 2);
    end else if (bus.halt_i) begin
      // halt wins over everything; PC frozen
    end else if (want != 0) begin
      if (bus.ihit) begin
        p = 1; s = 2'(want); fi = 1; fx = (want != 2);
      end else h = 1;
    end else begin
      ps = bus.pred_hit;
      p  = bus.ihit & ~bus.stall_i;
    end
  endtask

  task automatic step();
    logic p, ps, fi, fx, h;
    logic [1:0] s;
    int want;
    @(negedge CLK);
    expect_now(p, s, ps, fi, fx, h);
    chk("pcen",       bus.pcen,       p);
    chk("PCSrc",      bus.PCSrc,      s);
    chk("psel",       bus.psel,       ps);
    chk("flush_ifid", bus.flush_ifid, fi);
    chk("flush_idex", bus.flush_idex, fx);
    chk("pipe_hold",  bus.pipe_hold,  h);
    chk("halted",     bus.halted,     m_halted);
`ifdef FETCH_CTRL_STATS_EN
    chk("redirect_cnt", redirect_cnt, m_redir);
    chk("pend_cnt",     pend_cnt,     m_pend);
`endif
    want = bus.br_req ? 3 : bus.jr_req ? 1 : bus.j_req ? 2 : 0;
    @(posedge CLK);
    if (nRST) begin
      if (p && s != 0 && m_redir < SAT) m_redir++;
      if (m_waiting && m_pend < SAT) m_pend++;
      if (m_halted) ;
      else if (m_waiting) begin
        if (bus.ihit) m_waiting = 0;
      end else if (bus.halt_i) m_halted = 1;
      else if (want != 0 && !bus.ihit) begin
        m_waiting = 1;
        m_src     = want;
      end
    end
    #1;
  endtask

  task automatic drive(input logic ih, st, hl, br, jr, j, pr);
    bus.ihit = ih; bus.stall_i = st; bus.halt_i = hl;
    bus.br_req = br; bus.jr_req = jr; bus.j_req = j; bus.pred_hit = pr;
    #2;
  endtask

  task automatic drive_rand();
    bus.ihit     = ($urandom_range(0, 9) < 7);
    bus.stall_i  = ($urandom_range(0, 3) == 0);
    bus.halt_i   = ($urandom_range(0, 39) == 0);
    bus.br_req   = ($urandom_range(0, 6) == 0);
    bus.jr_req   = ($urandom_range(0, 6) == 0);
    bus.j_req    = ($urandom_range(0, 6) == 0);
    bus.pred_hit = $urandom_range(0, 1);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    model_reset();
    drive(1, 0, 0, 0, 0, 0, 1);
    step();
    drive_rand();
    step();
    nRST = 1'b1;
  endtask

  initial begin
    int halt_cycles;
    drive(1, 0, 0, 0, 0, 0, 1);
    model_reset();
    // Reset state with ihit high: outputs still quiet.
    chk("rst_pcen",  bus.pcen,      0);
    chk("rst_hold",  bus.pipe_hold, 0);
    chk("rst_flush", {bus.flush_ifid, bus.flush_idex}, 0);
    do_reset();

    // Plain sequential fetch.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("seq_pcen", bus.pcen, 1);
      chk("seq_src",  bus.PCSrc, 0);
      chk("seq_flush", {bus.flush_ifid, bus.flush_idex}, 0);
      step();
    end

    // br + j with hit: branch wins, both flushes, stay in RUN.
    drive(1, 0, 0, 1, 0, 1, 0);
    chk("brj_src",   bus.PCSrc, 3);
    chk("brj_pcen",  bus.pcen, 1);
    chk("brj_flush", {bus.flush_ifid, bus.flush_idex}, 2'b11);
    step();
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("brj_run", {bus.pcen, bus.pipe_hold}, 2'b10);
    step();

    // jr miss for two cycles, then hit.
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("jr_c1", {bus.pipe_hold, bus.pcen}, 2'b10);
    step();
    chk("jr_c2", {bus.pipe_hold, bus.pcen}, 2'b10);
    step();
    drive(1, 0, 0, 0, 1, 0, 0);
    chk("jr_c3", {bus.pipe_hold, bus.pcen, bus.PCSrc}, {2'b11, 2'd1});
    step();
`ifdef FETCH_CTRL_STATS_EN
    chk("jr_pend_cnt", pend_cnt, 2);
`endif

    // Pending branch ignores j_req and halt_i.
    do_reset();
    drive(0, 0, 0, 1, 0, 0, 0);
    step();
    drive(1, 1, 1, 0, 0, 1, 0);
    chk("pend_src",  bus.PCSrc, 3);
    chk("pend_pcen", bus.pcen, 1);
    step();
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("pend_nohalt", bus.halted, 0);
    chk("pend_run",    bus.pcen, 1);
    step();

    // Halt beats a same-cycle branch and sticks until reset.
    do_reset();
    drive(1, 0, 1, 1, 0, 0, 0);
    chk("halt_pcen",  bus.pcen, 0);
    chk("halt_flush", {bus.flush_ifid, bus.flush_idex}, 0);
    step();
    for (int i = 0; i < 6; i++) begin
      drive_rand();
      #2;
      chk("halt_sticky", {bus.halted, bus.pcen}, 2'b10);
      step();
    end
    do_reset();
    chk("halt_clear", bus.halted, 0);

    // Stall with prediction, then release.
    drive(1, 1, 0, 0, 0, 0, 1);
    chk("stall_pcen", {bus.pcen, bus.psel}, 2'b01);
    step();
    drive(1, 0, 0, 0, 0, 0, 1);
    chk("unstall_pcen", bus.pcen, 1);
    step();

    // Randomized traffic with occasional resets; halts are escaped via reset.
    halt_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 79) == 0 || halt_cycles > 8) begin
        do_reset();
        halt_cycles = 0;
      end
      drive_rand();
      step();
      halt_cycles = m_halted ? halt_cycles + 1 : 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 Parameter: CNT_W, 32, width of statistics counters (used only when FETCH_CTRL_STATS_EN is defined).
REQ-002 CLK  in  1  clock; all state updates on the rising edge.
REQ-003 nRST  in  1  reset, asynchronous, active-low.
REQ-004 ihit  in  1  instruction memory returned the current fetch this cycle.
REQ-005 stall_i  in  1  hazard-unit stall of the fetch/decode stages.
REQ-006 halt_i  in  1  halt instruction committed.
REQ-007 br_req  in  1  taken-branch redirect resolved in EX.
REQ-008 jr_req  in  1  jr redirect resolved in EX.
REQ-009 j_req  in  1  jump redirect resolved in ID.
REQ-010 pred_hit  in  1  predictor supplies a valid predicted PC.
REQ-011 pcen  out  1  PC register write enable.
REQ-012 PCSrc  out  2  next-PC select: 0 sequential/predicted, 1 jr, 2 j, 3 branch.
REQ-013 psel  out  1  choose predicted PC when PCSrc=0.
REQ-014 flush_ifid  out  1  clear IF/ID latch.
REQ-015 flush_idex  out  1  clear ID/EX latch.
REQ-016 pipe_hold  out  1  freeze ID/EX and EX/MEM latches so redirect targets stay stable.
REQ-017 halted  out  1  core is halted.
REQ-018 redirect_cnt, pend_cnt  out  CNT_W each  statistics (present only with FETCH_CTRL_STATS_EN).

Function
REQ-019 FSM states SHALL be RUN, PEND, HALT.
REQ-020 Redirect priority SHALL be br_req > jr_req > j_req; br_req and jr_req together select branch.
REQ-021 RUN, halt_i=1: outputs pcen=0, no flush; next state HALT; halt_i SHALL override any redirect request.
REQ-022 RUN, redirect with ihit=1: pcen=1, PCSrc=selected source, flush_ifid=1, flush_idex=1 only for br/jr; stay RUN.
REQ-023 RUN, redirect with ihit=0: pcen=0, pipe_hold=1, latch selected source; next state PEND.
REQ-024 Redirect SHALL take effect regardless of stall_i (the stalled instruction is wrong-path).
REQ-025 RUN, no redirect: PCSrc=0, psel=pred_hit, pcen=ihit & ~stall_i, no flush, pipe_hold=0.
REQ-026 PEND: PCSrc=latched source, pipe_hold=1, pcen=ihit; flushes per REQ-022 in the cycle pcen=1; then RUN.
REQ-027 PEND SHALL ignore new br_req/jr_req/j_req, stall_i and halt_i (all are wrong-path or frozen).
REQ-028 HALT: pcen=0, halted=1, all flush/pipe_hold 0; HALT SHALL be exited only by reset.
REQ-029 Outputs pcen, PCSrc, psel, flush_*, pipe_hold SHALL be combinational from state and inputs (zero latency); halted SHALL be registered (asserted the cycle after HALT entry).

Reset
REQ-030 nRST low SHALL force state RUN, latched source 0, halted 0, counters 0.
REQ-031 While nRST low, pcen, flush_ifid, flush_idex, pipe_hold SHALL be 0.
REQ-032 Reset asserted in PEND SHALL discard the pending redirect.

Configuration
REQ-033 Macro FETCH_CTRL_STATS_EN defined: redirect_cnt increments on each applied redirect (pcen=1 with PCSrc!=0); pend_cnt increments each cycle in PEND; both saturate at all-ones.
REQ-034 Macro undefined: counter ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-035 pcsrc_t enum (PC_SEQ=0, PC_JR=1, PC_J=2, PC_BR=3) and fctrl_state_t SHALL reside in the shared cpu_types_pkg.
REQ-036 Saturating counter SHALL be a sub-module fetch_ctrl_sat_cnt, instantiated twice under FETCH_CTRL_STATS_EN.

Verification
REQ-037 Reset, then ihit=1, stall_i=0, no requests for 3 cycles -> pcen=1, PCSrc=0 each cycle, no flush.
REQ-038 br_req=1, j_req=1, ihit=1 -> PCSrc=3, pcen=1, flush_ifid=1, flush_idex=1, state RUN.
REQ-039 jr_req=1, ihit=0 for 2 cycles then 1 -> pipe_hold=1 for 3 cycles, pcen=1 with PCSrc=1 only in 3rd, pend_cnt=2.
REQ-040 In PEND assert j_req=1, halt_i=1 -> ignored; latched PCSrc still applied; halted stays 0.
REQ-041 halt_i=1 together with br_req=1 in RUN -> pcen=0 that cycle, halted=1 next cycle and stays 1 under any input until nRST.
REQ-042 stall_i=1, pred_hit=1, no redirect -> pcen=0, psel=1; drop stall_i -> pcen=1.
